// File: rtl/clk_ratio_gen.sv
// Fractional clock-enable generator: each channel emits ce pulses at density num/den
// using a first-order accumulator; a small config FSM loads new ratios one channel at a time.
module clk_ratio_gen #(
  parameter int CHANNELS    = 2,
  parameter int W           = 16,
  parameter int DEFAULT_NUM = 27,
  parameter int DEFAULT_DEN = 50,
  parameter int SETTLE      = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SW = $clog2(SETTLE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [W-1:0]        cfg_num,
  input  logic [W-1:0]        cfg_den,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] locked
);

  // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE after the first post-reset edge.
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_ERR} cfg_state_t;

  localparam logic [CW:0] CHAN_LIM = CHANNELS[CW:0];

  cfg_state_t      r_state;
  cfg_state_t      w_state_nxt;
  logic            r_live;
  logic [CW-1:0]   r_req_chan;
  logic [W-1:0]    r_req_num;
  logic [W-1:0]    r_req_den;
  logic            w_req_bad;
  logic            w_accept;

  assign w_req_bad = (cfg_den == '0) || (cfg_num > cfg_den) || ({1'b0, cfg_chan} >= CHAN_LIM);
  assign w_accept  = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_live     <= 1'b0;
      r_req_chan <= '0;
      r_req_num  <= '0;
      r_req_den  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_req_chan <= cfg_chan;
        r_req_num  <= cfg_num;
        r_req_den  <= cfg_den;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    cfg_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = r_live;
        if (w_accept) w_state_nxt = w_req_bad ? S_ERR : S_APPLY;
      end
      S_APPLY: w_state_nxt = S_IDLE;
      S_ERR: begin
        cfg_err     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [W-1:0]  r_num;
    logic [W-1:0]  r_den;
    logic [W:0]    r_acc;
    logic [SW-1:0] r_cnt;
    logic          r_ce;
    logic [W:0]    w_sum;
    logic          w_load;

    assign w_sum     = r_acc + {1'b0, r_num};
    assign w_load    = (r_state == S_APPLY) && (r_req_chan == CW'(g));
    assign ce[g]     = r_ce;
    assign locked[g] = (r_cnt == SW'(SETTLE));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_num <= W'(DEFAULT_NUM);
        r_den <= W'(DEFAULT_DEN);
        r_acc <= '0;
        r_cnt <= '0;
        r_ce  <= 1'b0;
      end else if (w_load) begin
        // Reload restarts phase and lock even if the ratio is unchanged.
        r_num <= r_req_num;
        r_den <= r_req_den;
        r_acc <= '0;
        r_cnt <= '0;
        r_ce  <= 1'b0;
      end else if (r_num == '0) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ce  <= 1'b0;
      end else begin
        if (w_sum >= {1'b0, r_den}) begin
          r_ce  <= 1'b1;
          r_acc <= w_sum - {1'b0, r_den};
        end else begin
          r_ce  <= 1'b0;
          r_acc <= w_sum;
        end
        if (r_cnt != SW'(SETTLE)) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_gen.sv
// Bench for clk_ratio_gen: closed-form ratio model (pulses after k edges = floor(k*num/den))
// compared every cycle, plus directed literal checks of the key scenarios.
module tb_clk_ratio_gen;
  localparam int CH = 3;
  localparam int W  = 16;
  localparam int ST = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [W-1:0]  cfg_num;
  logic [W-1:0]  cfg_den;
  logic          cfg_err;
  logic [CH-1:0] ce;
  logic [CH-1:0] locked;

  int n_checks = 0;
  int n_fail   = 0;

  clk_ratio_gen #(.CHANNELS(CH), .W(W), .DEFAULT_NUM(27), .DEFAULT_DEN(50), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
    .ce(ce), .locked(locked)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model
  int            m_num [CH];
  int            m_den [CH];
  longint        m_k   [CH];
  int            m_pend;
  int            m_rchan, m_rnum, m_rden;
  logic [CH-1:0] e_ce, e_locked;
  logic          e_ready, e_err;

  always @(posedge clk or posedge reset) begin
    int  ld;
    bit  bad;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_num[c] = 27; m_den[c] = 50; m_k[c] = 0;
      end
      m_pend = 0; e_ce = '0; e_locked = '0; e_ready = 1'b0; e_err = 1'b0;
    end else begin
      ld = -1;
      if (m_pend == 1) begin
        ld = m_rchan; m_pend = 0; e_ready = 1'b1; e_err = 1'b0;
      end else if (m_pend == 2) begin
        m_pend = 0; e_ready = 1'b1; e_err = 1'b0;
      end else if (cfg_valid && e_ready) begin
        bad = (cfg_den == 0) || (cfg_num > cfg_den) || (int'(cfg_chan) >= CH);
        m_rchan = int'(cfg_chan); m_rnum = int'(cfg_num); m_rden = int'(cfg_den);
        m_pend = bad ? 2 : 1; e_ready = 1'b0; e_err = bad;
      end else begin
        e_ready = 1'b1;
      end
      for (int c = 0; c < CH; c++) begin
        if (c == ld) begin
          m_num[c] = m_rnum; m_den[c] = m_rden; m_k[c] = 0;
          e_ce[c] = 1'b0; e_locked[c] = 1'b0;
        end else if (m_num[c] == 0) begin
          m_k[c] = 0; e_ce[c] = 1'b0; e_locked[c] = 1'b0;
        end else begin
          m_k[c]++;
          e_ce[c] = ((m_k[c] * m_num[c]) / m_den[c]) != (((m_k[c] - 1) * m_num[c]) / m_den[c]);
          e_locked[c] = (m_k[c] >= ST);
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    check("ce", 32'(ce), 32'(e_ce));
    check("locked", 32'(locked), 32'(e_locked));
    check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    check("cfg_err", 32'(cfg_err), 32'(e_err));
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_req(input int ch, input int n, input int d);
    cfg_valid = 1'b1;
    cfg_chan  = ch[1:0];
    cfg_num   = n[W-1:0];
    cfg_den   = d[W-1:0];
    tick(1);
    cfg_valid = 1'b0;
    cfg_chan  = 2'($urandom);
    cfg_num   = W'($urandom);
    cfg_den   = W'($urandom);
  endtask

  int et_ch [3] = '{0, 0, 3};
  int et_n  [3] = '{5, 1, 1};
  int et_d  [3] = '{3, 0, 4};

  initial begin
    int cnt;
    logic [CH-1:0] lk;
    reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_num = '0; cfg_den = '0;
    tick(3);
    check("reset_ce", 32'(ce), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_ready", 32'(cfg_ready), 32'h0);
    reset = 1'b0;
    #1 check("ready_before_edge1", 32'(cfg_ready), 32'h0);

    // defaults 27/50
    cnt = 0;
    for (int e = 1; e <= 52; e++) begin
      tick(1);
      if (e == 1) check("ready_edge1", 32'(cfg_ready), 32'h1);
      if (e == 1) check("ce0_edge1", 32'(ce[0]), 32'h0);
      if (e == 2) check("ce0_edge2", 32'(ce[0]), 32'h1);
      if (e == 15) check("locked_edge15", 32'(locked), 32'h0);
      if (e == 16) check("locked_edge16", 32'(locked), 32'h7);
      if (e >= 3) cnt += int'(ce[0]);
    end
    check("ce0_pulses_per_50", 32'(cnt), 32'd27);

    // ch1 1/4
    cfg_req(1, 1, 4);
    check("apply_ready_low", 32'(cfg_ready), 32'h0);
    tick(1);
    check("apply_ready_back", 32'(cfg_ready), 32'h1);
    check("ch1_locked_cleared", 32'(locked[1]), 32'h0);
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      check("ch1_quarter", 32'(ce[1]), 32'((j % 4) == 0));
    end
    tick(20);

    // rejected requests
    for (int t = 0; t < 3; t++) begin
      lk = locked;
      cfg_req(et_ch[t], et_n[t], et_d[t]);
      check("err_pulse", 32'(cfg_err), 32'h1);
      check("err_ready_low", 32'(cfg_ready), 32'h0);
      check("err_locked_kept", 32'(locked), 32'(lk));
      tick(1);
      check("err_cleared", 32'(cfg_err), 32'h0);
      check("err_ready_back", 32'(cfg_ready), 32'h1);
    end

    // ch2 7/7, then same ratio again
    for (int r = 0; r < 2; r++) begin
      cfg_req(2, 7, 7);
      tick(1);
      check("ch2_locked_cleared", 32'(locked[2]), 32'h0);
      for (int j = 1; j <= 18; j++) begin
        tick(1);
        check("ch2_full_rate", 32'(ce[2]), 32'h1);
        if (j == 15) check("ch2_locked15", 32'(locked[2]), 32'h0);
        if (j == 16) check("ch2_locked16", 32'(locked[2]), 32'h1);
      end
    end

    // ch0 off, then 3/8
    cfg_req(0, 0, 5);
    tick(1);
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      check("ch0_off_ce", 32'(ce[0]), 32'h0);
      check("ch0_off_locked", 32'(locked[0]), 32'h0);
    end
    cfg_req(0, 3, 8);
    tick(1);
    cnt = 0;
    for (int j = 1; j <= 16; j++) begin
      tick(1);
      cnt += int'(ce[0]);
      if (j == 8) check("ch0_3of8", 32'(cnt), 32'd3);
      if (j == 15) check("ch0_relock15", 32'(locked[0]), 32'h0);
      if (j == 16) check("ch0_relock16", 32'(locked[0]), 32'h1);
    end
    check("ch0_6of16", 32'(cnt), 32'd6);
    tick(4);

    // reset during a pending APPLY
    check("all_locked", 32'(locked), 32'h7);
    cfg_req(1, 1, 4);
    #2 reset = 1'b1;
    #1;
    check("async_ce", 32'(ce), 32'h0);
    check("async_locked", 32'(locked), 32'h0);
    check("async_ready", 32'(cfg_ready), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("rst_ready_edge1", 32'(cfg_ready), 32'h1);
    check("rst_ce_edge1", 32'(ce), 32'h0);
    tick(1);
    check("rst_ce_edge2", 32'(ce), 32'h7);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_den   = W'($urandom_range(0, 12));
      cfg_num   = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom_range(0, 14));
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end else begin
        tick(1);
      end
    end
    cfg_valid = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_ratio_gen.md
CLK_RATIO_GEN -- requirements
Module: clk_ratio_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter W, default 16: width of the ratio numerator and denominator.
REQ-003 SHALL have parameter DEFAULT_NUM, default 27: numerator loaded at reset.
REQ-004 SHALL have parameter DEFAULT_DEN, default 50: denominator loaded at reset.
REQ-005 SHALL have parameter SETTLE, default 16: cycles from ratio load to locked.
REQ-006 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port cfg_valid, input, 1: config request valid.
REQ-009 SHALL have port cfg_ready, output, 1: config request accepted when high with cfg_valid.
REQ-010 SHALL have port cfg_chan, input, max(1,clog2(CHANNELS)): target channel.
REQ-011 SHALL have port cfg_num, input, W: requested numerator.
REQ-012 SHALL have port cfg_den, input, W: requested denominator.
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse on rejected request.
REQ-014 SHALL have port ce, output, CHANNELS: per-channel registered clock-enable pulses.
REQ-015 SHALL have port locked, output, CHANNELS: per-channel ratio-stable flag.

Function
REQ-016 Each channel SHALL hold num, den (W bits) and accumulator acc (W+1 bits); it is active when num!=0.
REQ-017 On each edge, an active channel SHALL compute s=acc+num and, if s>=den, set ce[i]<=1 and acc<=s-den; otherwise ce[i]<=0 and acc<=s.
REQ-018 Long-run ce[i] density SHALL be exactly num/den; over any den consecutive cycles after load, exactly num pulses.
REQ-019 An inactive channel (num==0) SHALL hold ce[i]=0, locked[i]=0, acc=0.
REQ-020 num==den SHALL give ce[i]=1 every cycle.
REQ-021 Config FSM states: IDLE (cfg_ready=1), APPLY (cfg_ready=0), ERR (cfg_ready=0, cfg_err=1).
REQ-022 IDLE with cfg_valid=1: request valid -> APPLY; request invalid -> ERR; otherwise stay IDLE.
REQ-023 Request invalid: cfg_den==0, or cfg_num>cfg_den, or cfg_chan>=CHANNELS.
REQ-024 APPLY SHALL last one cycle: load target num/den, clear its acc, ce and locked, restart its settle counter, then -> IDLE.
REQ-025 ERR SHALL last one cycle with no channel state change, then -> IDLE.
REQ-026 Request inputs SHALL be captured on the accepting edge; later changes are ignored.
REQ-027 Non-target channels SHALL run undisturbed during APPLY/ERR.
REQ-028 Per-channel settle counter SHALL count cycles while active, saturating at SETTLE; locked[i]=1 when saturated.
REQ-029 Reconfiguring a channel to its current num/den SHALL still perform the full APPLY (phase reset, locked cleared).

Reset
REQ-030 During reset: acc=0, num=DEFAULT_NUM, den=DEFAULT_DEN, ce=0, locked=0, cfg_err=0, cfg_ready=0, FSM=IDLE, settle counters=0.
REQ-031 cfg_ready SHALL go high at the first edge after reset deassertion; channels start accumulating on that same edge.
REQ-032 Reset asserted mid-APPLY or mid-ERR SHALL discard the request; defaults are restored.

Verification
REQ-033 Release reset with defaults -> first ce[0] high after 2nd edge (acc 0->27->4); exactly 27 pulses per 50 cycles on each channel; locked high after 16 cycles.
REQ-034 Apply ch1 num=1, den=4 -> cfg_ready low 1 cycle; ce[1] high every 4th cycle starting 4 edges after APPLY; ch0 pattern unchanged.
REQ-035 Request num=5, den=3 (also den=0, chan=CHANNELS) -> cfg_err 1 cycle, cfg_ready low 1 cycle, no ce/locked change.
REQ-036 Apply num=7, den=7 -> ce continuously 1 from first edge after APPLY; locked after 16 cycles.
REQ-037 Apply num=0 to ch0 -> ce[0] and locked[0] stay 0; later apply num=3, den=8 -> 3 pulses per 8 cycles, relock after 16.
REQ-038 Assert reset with locked=11 and APPLY pending -> all outputs 0 asynchronously; after release the default 27/50 pattern resumes.
